pulse_run_ctrl: RTL and testbench
=================================

# pulse_run_ctrl

Parametrised run-control block for gated timebase pulses. It accepts a single-cycle `pulse` strobe, typically the 1 Hz tick, and gates it by the `start`/`pause` controls through a four-state FSM. The passed pulses are divided by `DIV`, and the resulting ticks are counted against a programmable `limit` in either continuous (modulo) or one-shot mode. It sits between the timebase divider and the display/counter logic, and is the successor of the simple start/pause pulse gate, adding pause-hold, prescaling, counting and terminal-count handling.

## Interface
- `CNT_W`, default 16: width of tick counter and `limit`.
- `DIV`, default 1: input pulses per output tick, ≥1; `DIV`=1 passes every gated pulse.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `pulse`, input, 1: single-cycle timebase strobe.
- `start`, input, 1: level; run enable.
- `pause`, input, 1: level; freezes counting while high.
- `clear`, input, 1: synchronous clear of count and prescaler.
- `mode`, input, 1: 0 = continuous (modulo `limit`), 1 = one-shot.
- `limit`, input, `CNT_W`: terminal value; 0 means 2^`CNT_W`.
- `pulse_out`, output, 1: registered gated/divided tick, one cycle wide.
- `count`, output, `CNT_W`: tick count.
- `wrap`, output, 1: one-cycle strobe on continuous-mode wrap.
- `done`, output, 1: high while in DONE.
- `state`, output, 2: current state, for debug and status.

## Operation
- **States:** IDLE=00, RUN=01, PAUSED=10, DONE=11.
- **IDLE:**
  - `start`&!`pause` → RUN.
  - `start`&`pause` → PAUSED.
  - Otherwise stay in IDLE.
- **RUN:**
  - !`start` → IDLE.
  - else `pause` → PAUSED.
  - else a one-shot terminal tick → DONE.
  - Priority order: !`start` > `pause` > terminal.
- **PAUSED:**
  - !`start` → IDLE.
  - !`pause` → RUN.
- **DONE:**
  - !`start` or `clear` → IDLE.
  - `pause` is ignored.
- **Accepted pulse:** `pulse`=1 while `state`=RUN, `start`=1 and `pause`=0 in the same cycle. A pulse arriving in the cycle a stop or pause is requested is dropped.
- **Prescaler:**
  - An internal counter runs 0..`DIV`-1 and increments on each accepted pulse.
  - An accepted pulse with prescaler = `DIV`-1 is a *tick*, and the prescaler returns to 0.
  - The prescaler holds in PAUSED and DONE.
  - It clears on entry to IDLE and on `clear`.
- **Count update on a tick:**
  - Let n = (`count`+1) mod 2^`CNT_W`.
  - Continuous mode: if n == `limit`, then `count`←0 and `wrap` pulses; else `count`←n.
  - One-shot mode: `count`←n; if n == `limit`, go to DONE.
  - With `limit`=0 the comparison matches at the natural 2^`CNT_W` rollover.
- **Count persistence:** `count` holds across PAUSED, IDLE and DONE. Only `clear` or reset zeroes it (stopwatch semantics).
- **`clear`:**
  - Zeroes `count` and the prescaler in any state.
  - Has priority over a simultaneous tick: that tick is dropped and no `pulse_out` is produced.
  - Does not change state except DONE → IDLE.
- **`limit` and `mode` changes:** both are sampled every cycle. If `limit` is lowered below `count`, the count runs on until mod-2^`CNT_W` equality; no saturation.
- **Out-of-range `DIV`:** `DIV`<1 is illegal; the elaboration-time check fails.

## Timing
- **Reset values:** `state`=IDLE, `count`=0, prescaler=0, and `pulse_out`=`wrap`=`done`=0.
- **Registered outputs:** every output is a flop; there are no combinational input→output paths.
- **Tick latency:** a tick in cycle k gives, after edge k+1:
  - `pulse_out`=1 for exactly one cycle;
  - `count` updated in the same cycle;
  - `wrap` in the same cycle when it applies.
- **State latency:** a state change requested in cycle k is visible after edge k+1.
- **One-shot completion:** the terminal tick gives `pulse_out`=1 and `done`=1 in the same cycle. `done` then stays high until leaving DONE.
- **Maximum tick rate:** back-to-back pulses with `DIV`=1 give back-to-back `pulse_out` cycles.
- **Reset mid-operation:** reset takes effect at the next edge with `rst`=0 and overrides all other inputs.

## Test plan
- Reset: with `rst`=0 for 2 cycles while `start`=1 and pulses toggle → all outputs 0, `state`=00. After release, the first accepted pulse gives `pulse_out` one cycle later.
- Gating: `DIV`=1 and `start`=1; 5 pulses, then `pause`=1 with 3 pulses, then `pause`=0 with 2 pulses → 7 `pulse_out`s and `count`=7. A pulse coincident with the `pause` rise is dropped.
- Prescale with pause hold: `DIV`=4 and 10 accepted pulses with a pause after pulse 3 → `count`=2 and the prescaler left at 2. Pulse ticks land on accepted pulses 4 and 8.
- Continuous wrap: `mode`=0, `limit`=3, `DIV`=1, 7 pulses → `count` goes 1,2,0,1,2,0,1. `wrap` pulses with the 3rd and 6th `pulse_out`.
- One-shot: `mode`=1, `limit`=5, 8 pulses → `done`=1 together with the 5th `pulse_out`; `count`=5, no further `pulse_out`. Dropping `start` → IDLE with `count`=5 retained. Then `clear` → `count`=0.
- Priorities: `clear` and a tick in the same cycle → `count`=0 and no `pulse_out`. `start`=0 and `pause`=1 together in RUN → IDLE. `limit`=0 with `CNT_W`=4 in one-shot → DONE after 16 ticks with `count`=0.

Source files
------------

// File: rtl/pulse_run_ctrl.sv
// Run-control gate for timebase pulses: start/pause FSM,
// DIV prescaler and limit-based tick counter.
module pulse_run_ctrl #(
   parameter int CNT_W = 16,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic             mode,
   input  logic [CNT_W-1:0] limit,
   output logic             pulse_out,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic             done,
   output logic [1:0]       state
);

   if (DIV < 1) begin : g_bad_div
      $error("pulse_run_ctrl: DIV must be >= 1");
   end

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_PAUSED = 2'b10,
      S_DONE   = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pout_q, wrap_q, done_q;
   logic             wrap_d;

   logic             accept, tick, ev, hit;
   logic [CNT_W-1:0] cnt_n;

   always_comb begin
      accept = pulse & start & ~pause & (state_q == S_RUN);
      tick   = accept & (pre_q == PMAX);
      ev     = tick & ~clear;
      cnt_n  = count_q + 1'b1;
      hit    = (cnt_n == limit);

      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = pause ? S_PAUSED : S_RUN;
         end
         S_RUN: begin
            if (!start)            state_d = S_IDLE;
            else if (pause)        state_d = S_PAUSED;
            else if (ev && mode && hit) state_d = S_DONE;
         end
         S_PAUSED: begin
            if (!start)      state_d = S_IDLE;
            else if (!pause) state_d = S_RUN;
         end
         S_DONE: begin
            if (!start || clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Prescaler only moves on accepted pulses; IDLE always holds it at 0
      pre_d = pre_q;
      if (clear || state_d == S_IDLE) pre_d = '0;
      else if (accept)                pre_d = tick ? '0 : pre_q + 1'b1;

      count_d = count_q;
      if (clear)   count_d = '0;
      else if (ev) count_d = (!mode && hit) ? '0 : cnt_n;

      wrap_d = ev & ~mode & hit;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         count_q <= '0;
         pout_q  <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         count_q <= count_d;
         pout_q  <= ev;
         wrap_q  <= wrap_d;
         done_q  <= (state_d == S_DONE);
      end
   end

   assign pulse_out = pout_q;
   assign count     = count_q;
   assign wrap      = wrap_q;
   assign done      = done_q;
   assign state     = state_q;

endmodule

// File: tb/tb_pulse_run_ctrl.sv
// Directed bench for pulse_run_ctrl: three instances cover
// DIV=1, DIV=4 and the 4-bit limit=0 rollover case.
module tb_pulse_run_ctrl;

   logic        clk = 1'b0;
   logic        rst, pulse, start, pause, clear, mode;
   logic [15:0] limit;

   logic        po_a, wr_a, dn_a;
   logic [15:0] cnt_a;
   logic [1:0]  st_a;
   logic        po_b, wr_b, dn_b;
   logic [15:0] cnt_b;
   logic [1:0]  st_b;
   logic        po_c, wr_c, dn_c;
   logic [3:0]  cnt_c;
   logic [1:0]  st_c;

   int errs = 0;
   int nchk = 0;
   int npo  = 0;

   always #5 clk = ~clk;

   pulse_run_ctrl #(.CNT_W(16), .DIV(1)) u_a (
      .clk(clk), .rst(rst), .pulse(pulse), .start(start),
      .pause(pause), .clear(clear), .mode(mode), .limit(limit),
      .pulse_out(po_a), .count(cnt_a), .wrap(wr_a),
      .done(dn_a), .state(st_a));

   pulse_run_ctrl #(.CNT_W(16), .DIV(4)) u_b (
      .clk(clk), .rst(rst), .pulse(pulse), .start(start),
      .pause(pause), .clear(clear), .mode(mode), .limit(limit),
      .pulse_out(po_b), .count(cnt_b), .wrap(wr_b),
      .done(dn_b), .state(st_b));

   pulse_run_ctrl #(.CNT_W(4), .DIV(1)) u_c (
      .clk(clk), .rst(rst), .pulse(pulse), .start(start),
      .pause(pause), .clear(clear), .mode(mode), .limit(limit[3:0]),
      .pulse_out(po_c), .count(cnt_c), .wrap(wr_c),
      .done(dn_c), .state(st_c));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (po_a) npo++;
   endtask

   task automatic pulse1();
      pulse = 1'b1;
      step();
      pulse = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   int exp_cnt [7] = '{1, 2, 0, 1, 2, 0, 1};

   initial begin
      rst = 1'b0; start = 1'b1; pause = 1'b0; clear = 1'b0;
      mode = 1'b0; limit = 16'd0; pulse = 1'b1;

      // reset holds everything while start/pulse are active
      step();
      pulse = 1'b0;
      step();
      chk("rst_state", st_a, 2'b00);
      chk("rst_count", cnt_a, 0);
      chk("rst_pout", po_a, 0);
      chk("rst_wrap", wr_a, 0);
      chk("rst_done", dn_a, 0);

      rst = 1'b1;
      step();
      chk("run_entry", st_a, 2'b01);
      pulse1();
      chk("first_pout", po_a, 1);
      chk("first_count", cnt_a, 1);
      step();
      chk("pout_width", po_a, 0);

      // gating
      do_clear();
      chk("clr_count", cnt_a, 0);
      npo = 0;
      for (int i = 0; i < 5; i++) begin pulse1(); step(); end
      pause = 1'b1;
      pulse1();
      chk("pause_drop", po_a, 0);
      chk("paused_st", st_a, 2'b10);
      step();
      for (int i = 0; i < 2; i++) begin pulse1(); step(); end
      pause = 1'b0;
      step();
      chk("resume_st", st_a, 2'b01);
      for (int i = 0; i < 2; i++) begin pulse1(); step(); end
      chk("gate_npo", npo, 7);
      chk("gate_count", cnt_a, 7);

      // prescale with pause hold (u_b, DIV=4)
      do_clear();
      chk("b_clr", cnt_b, 0);
      for (int k = 1; k <= 10; k++) begin
         pulse1();
         chk($sformatf("b_tick%0d", k), po_b, (k == 4 || k == 8));
         step();
         if (k == 3) begin
            pause = 1'b1;
            step();
            pulse1();
            chk("b_pause_hold", po_b, 0);
            pulse1();
            pause = 1'b0;
            step();
         end
      end
      chk("b_count", cnt_b, 2);
      pulse1();
      chk("b_pre11", po_b, 0);
      step();
      pulse1();
      chk("b_pre12", po_b, 1);
      chk("b_count12", cnt_b, 3);

      // continuous wrap, back-to-back pulses
      do_clear();
      mode = 1'b0; limit = 16'd3;
      pulse = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         chk($sformatf("w_pout%0d", i), po_a, 1);
         chk($sformatf("w_cnt%0d", i), cnt_a, exp_cnt[i]);
         chk($sformatf("w_wrap%0d", i), wr_a, (i == 2 || i == 5));
      end
      pulse = 1'b0;
      step();
      chk("w_wrap_end", wr_a, 0);

      // one-shot
      do_clear();
      mode = 1'b1; limit = 16'd5;
      npo = 0;
      for (int i = 1; i <= 8; i++) begin
         pulse1();
         if (i == 4) chk("os_notdone", dn_a, 0);
         if (i == 5) begin
            chk("os_done", dn_a, 1);
            chk("os_pout5", po_a, 1);
            chk("os_state", st_a, 2'b11);
         end
         step();
      end
      chk("os_npo", npo, 5);
      chk("os_count", cnt_a, 5);
      start = 1'b0;
      step();
      chk("os_idle", st_a, 2'b00);
      chk("os_done_lo", dn_a, 0);
      chk("os_keep", cnt_a, 5);
      do_clear();
      chk("os_clear", cnt_a, 0);

      // priorities
      start = 1'b1;
      step();
      pulse1(); step();
      pulse1(); step();
      chk("pr_pre", cnt_a, 2);
      clear = 1'b1;
      pulse1();
      clear = 1'b0;
      chk("pr_clr_cnt", cnt_a, 0);
      chk("pr_clr_pout", po_a, 0);
      chk("pr_clr_st", st_a, 2'b01);
      start = 1'b0; pause = 1'b1;
      step();
      chk("pr_stop", st_a, 2'b00);

      // limit=0 one-shot with 4-bit counter
      pause = 1'b0; limit = 16'd0; mode = 1'b1;
      do_clear();
      start = 1'b1;
      step();
      for (int i = 1; i <= 16; i++) begin
         pulse1();
         if (i == 15) begin
            chk("c_cnt15", cnt_c, 15);
            chk("c_st15", st_c, 2'b01);
         end
      end
      chk("c_done", dn_c, 1);
      chk("c_cnt", cnt_c, 0);
      chk("c_state", st_c, 2'b11);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
